// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing path: screen geometry, colour format,
// blitter state encoding and a width helper.
package vga_pkg;

  localparam int COLOUR_W = 9;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [COLOUR_W-1:0] KEY_COLOUR_DEF = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bit width able to index 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster-order pixel counters and ROM address generator for one sprite tile.
// The address is a running counter seeded with the sprite base on accept.
module sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int TILE_W = 20,
  parameter int TILE_H = 20,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 11,
  parameter int PX_W   = clog2_min1(TILE_W),
  parameter int PY_W   = clog2_min1(TILE_H)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  input  logic [SEL_W-1:0]  sprite_sel,
  output logic [PX_W-1:0]   px,
  output logic [PY_W-1:0]   py,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              last
);

  localparam int TILE_N = TILE_W * TILE_H;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(TILE_W - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(TILE_H - 1);

  function automatic logic [ADDR_W-1:0] sprite_base(input logic [SEL_W-1:0] sel);
    return ADDR_W'(32'(sel) * TILE_N);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      px       <= '0;
      py       <= '0;
      rom_addr <= '0;
    end else if (clear) begin
      px       <= '0;
      py       <= '0;
      rom_addr <= sprite_base(sprite_sel);
    end else if (advance) begin
      rom_addr <= rom_addr + ADDR_W'(1);
      if (px == PX_LAST) begin
        px <= '0;
        py <= (py == PY_LAST) ? '0 : py + PY_W'(1);
      end else begin
        px <= px + PX_W'(1);
      end
    end
  end

  assign last = (px == PX_LAST) && (py == PY_LAST);

endmodule

// File: rtl/draw_sprite_tile.sv
// Tile blitter: copies one sprite from ROM onto a grid cell, one pixel write per
// cycle, with optional colour-key transparency and a start/busy/done handshake.
module draw_sprite_tile
  import vga_pkg::*;
#(
  parameter int TILE_W    = 20,
  parameter int TILE_H    = 20,
  parameter int N_SPRITES = 4,
  parameter int COLOUR_W  = vga_pkg::COLOUR_W,
  parameter int ROM_LAT   = 1,
  parameter int X_W       = $clog2(SCREEN_W),
  parameter int Y_W       = $clog2(SCREEN_H),
  parameter int KEY_EN    = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(KEY_COLOUR_DEF),
  localparam int SEL_W    = clog2_min1(N_SPRITES),
  localparam int ADDR_W   = clog2_min1(N_SPRITES * TILE_W * TILE_H)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [SEL_W-1:0]    sprite_sel,
  input  logic [3:0]          grid_x,
  input  logic [3:0]          grid_y,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int PX_W    = clog2_min1(TILE_W);
  localparam int PY_W    = clog2_min1(TILE_H);
  localparam int DRAIN_W = clog2_min1(ROM_LAT);

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [3:0]         gx_l, gy_l;
  logic [PX_W-1:0]    px, px_tap;
  logic [PY_W-1:0]    py, py_tap;
  logic               last, accept, fetching, vld_tap;
  logic [ROM_LAT-1:0] vld_p;
  logic [X_W-1:0]     x_p;
  logic [Y_W-1:0]     y_p;

  // Cell offset computed at full width, then wrapped onto the screen bus.
  function automatic logic [X_W-1:0] cell_x(input logic [3:0] g, input logic [PX_W-1:0] p);
    return X_W'(32'(g) * TILE_W + 32'(p));
  endfunction

  function automatic logic [Y_W-1:0] cell_y(input logic [3:0] g, input logic [PY_W-1:0] p);
    return Y_W'(32'(g) * TILE_H + 32'(p));
  endfunction

  assign accept   = (state == ST_IDLE) && start;
  assign fetching = (state == ST_FETCH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_FETCH;
          busy  <= 1'b1;
        end
        ST_FETCH: if (last) begin
          state     <= ST_DRAIN;
          drain_cnt <= '0;
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(ROM_LAT - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      gx_l <= grid_x;
      gy_l <= grid_y;
    end
  end

  sprite_addr_gen #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .SEL_W  (SEL_W),
    .ADDR_W (ADDR_W),
    .PX_W   (PX_W),
    .PY_W   (PY_W)
  ) u_addr_gen (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (accept),
    .advance    (fetching),
    .sprite_sel (sprite_sel),
    .px         (px),
    .py         (py),
    .rom_addr   (rom_addr),
    .last       (last)
  );

  // Stage p0..p(L-1): valid bit travels with the ROM read, aligned with rom_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fetching;
      for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Pixel coordinates ride L-1 stages; the final stage is the x/y register itself.
  generate
    if (ROM_LAT == 1) begin : g_no_dly
      assign px_tap  = px;
      assign py_tap  = py;
      assign vld_tap = fetching;
    end else begin : g_dly
      logic [PX_W-1:0] px_p [ROM_LAT-1];
      logic [PY_W-1:0] py_p [ROM_LAT-1];
      always_ff @(posedge clk) begin
        px_p[0] <= px;
        py_p[0] <= py;
        for (int i = 1; i < ROM_LAT - 1; i++) begin
          px_p[i] <= px_p[i-1];
          py_p[i] <= py_p[i-1];
        end
      end
      assign px_tap  = px_p[ROM_LAT-2];
      assign py_tap  = py_p[ROM_LAT-2];
      assign vld_tap = vld_p[ROM_LAT-2];
    end
  endgenerate

  // Output stage: screen coordinates registered alongside the returning ROM word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_p <= '0;
      y_p <= '0;
    end else if (vld_tap) begin
      x_p <= cell_x(gx_l, px_tap);
      y_p <= cell_y(gy_l, py_tap);
    end
  end

  assign x      = x_p;
  assign y      = y_p;
  assign colour = rom_q;
  assign plot   = vld_p[ROM_LAT-1] && ((KEY_EN == 0) || (rom_q != KEY_COLOUR));

endmodule

// File: tb/tb_draw_sprite_tile.sv
// Directed bench for draw_sprite_tile: three instances (plain, colour-keyed,
// three-cycle ROM) share stimulus; every output is predicted cycle by cycle.
module tb_draw_sprite_tile;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] sprite_sel;
  logic [3:0] grid_x, grid_y;

  logic        d_busy, d_done, d_plot;
  logic [10:0] d_rom_addr;
  logic [8:0]  d_rom_q, d_colour;
  logic [7:0]  d_x;
  logic [6:0]  d_y;

  logic        k_busy, k_done, k_plot;
  logic [10:0] k_rom_addr;
  logic [8:0]  k_rom_q, k_colour;
  logic [7:0]  k_x;
  logic [6:0]  k_y;

  logic        l_busy, l_done, l_plot;
  logic [10:0] l_rom_addr;
  logic [8:0]  l_rom_q, l_colour, l_q1, l_q2;
  logic [7:0]  l_x;
  logic [6:0]  l_y;

  int vectors     = 0;
  int miscompares = 0;
  int ndone;

  always #5 clk = ~clk;

  // ROM models: word = address (mod 512); keyed ROM is zero at even addresses.
  always_ff @(posedge clk) begin
    d_rom_q <= d_rom_addr[8:0];
    k_rom_q <= k_rom_addr[0] ? k_rom_addr[8:0] : 9'h000;
    l_q1    <= l_rom_addr[8:0];
    l_q2    <= l_q1;
    l_rom_q <= l_q2;
  end

  draw_sprite_tile #(.KEY_EN(0)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .sprite_sel(sprite_sel),
    .grid_x(grid_x), .grid_y(grid_y), .busy(d_busy), .done(d_done),
    .rom_addr(d_rom_addr), .rom_q(d_rom_q), .plot(d_plot), .x(d_x), .y(d_y),
    .colour(d_colour)
  );

  draw_sprite_tile u_key (
    .clk(clk), .resetn(resetn), .start(start), .sprite_sel(sprite_sel),
    .grid_x(grid_x), .grid_y(grid_y), .busy(k_busy), .done(k_done),
    .rom_addr(k_rom_addr), .rom_q(k_rom_q), .plot(k_plot), .x(k_x), .y(k_y),
    .colour(k_colour)
  );

  draw_sprite_tile #(.ROM_LAT(3), .KEY_EN(0)) u_lat3 (
    .clk(clk), .resetn(resetn), .start(start), .sprite_sel(sprite_sel),
    .grid_x(grid_x), .grid_y(grid_y), .busy(l_busy), .done(l_done),
    .rom_addr(l_rom_addr), .rom_q(l_rom_q), .plot(l_plot), .x(l_x), .y(l_y),
    .colour(l_colour)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected behaviour of one instance in draw-relative cycle c (start seen in cycle 0).
  task automatic chk_inst(input string nm, input int lat, input bit keyed, input int c,
                          input int sel, input int gx, input int gy, input bit ab,
                          input logic pl, input logic [7:0] xo, input logic [6:0] yo,
                          input logic [8:0] co, input logic bs, input logic dn,
                          input logic [10:0] ra);
    int k, a;
    bit dead, exp_pl;
    k      = c - 1 - lat;
    a      = sel * 400 + k;
    dead   = ab && (c >= 151);
    exp_pl = !dead && (k >= 0) && (k < 400) && (!keyed || (k % 2 == 1));
    chk($sformatf("%s plot c=%0d", nm, c), 32'(pl), 32'(exp_pl));
    if (exp_pl) begin
      chk($sformatf("%s x c=%0d", nm, c), 32'(xo), (gx * 20 + k % 20) % 256);
      chk($sformatf("%s y c=%0d", nm, c), 32'(yo), (gy * 20 + k / 20) % 128);
      chk($sformatf("%s colour c=%0d", nm, c), 32'(co), a % 512);
    end
    chk($sformatf("%s busy c=%0d", nm, c), 32'(bs), 32'(!dead && c >= 1 && c <= 400 + lat));
    chk($sformatf("%s done c=%0d", nm, c), 32'(dn), 32'(!ab && c == 401 + lat));
    if (!dead && c >= 1 && c <= 400)
      chk($sformatf("%s rom_addr c=%0d", nm, c), 32'(ra), sel * 400 + c - 1);
    if (dead) begin
      chk($sformatf("%s rom_addr after reset c=%0d", nm, c), 32'(ra), 0);
      chk($sformatf("%s x after reset c=%0d", nm, c), 32'(xo), 0);
      chk($sformatf("%s y after reset c=%0d", nm, c), 32'(yo), 0);
    end
  endtask

  // pert: 0 none, 1 start with another cell at cycle 100, 2 resetn low in cycle 150
  task automatic run_draw(input int sel, input int gx, input int gy, input int pert);
    sprite_sel = 2'(sel);
    grid_x     = 4'(gx);
    grid_y     = 4'(gy);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    sprite_sel = ~sprite_sel;
    grid_x     = grid_x + 4'd5;
    grid_y     = grid_y + 4'd3;
    for (int c = 1; c <= 410; c++) begin
      if (pert == 1) begin
        start = (c == 100);
        if (c == 100) begin
          grid_x = 4'd7; grid_y = 4'd5; sprite_sel = 2'd3;
        end
      end
      if (pert == 2) resetn = (c != 150);
      chk_inst("dut", 1, 1'b0, c, sel, gx, gy, pert == 2, d_plot, d_x, d_y, d_colour,
               d_busy, d_done, d_rom_addr);
      chk_inst("key", 1, 1'b1, c, sel, gx, gy, pert == 2, k_plot, k_x, k_y, k_colour,
               k_busy, k_done, k_rom_addr);
      chk_inst("lat3", 3, 1'b0, c, sel, gx, gy, pert == 2, l_plot, l_x, l_y, l_colour,
               l_busy, l_done, l_rom_addr);
      @(posedge clk); #1;
    end
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; sprite_sel = '0; grid_x = '0; grid_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset d_busy", 32'(d_busy), 0);
    chk("reset d_done", 32'(d_done), 0);
    chk("reset d_plot", 32'(d_plot), 0);
    chk("reset d_x", 32'(d_x), 0);
    chk("reset d_y", 32'(d_y), 0);
    chk("reset d_rom_addr", 32'(d_rom_addr), 0);
    chk("reset k_plot", 32'(k_plot), 0);
    chk("reset l_plot", 32'(l_plot), 0);
    chk("reset l_busy", 32'(l_busy), 0);
    chk("reset l_rom_addr", 32'(l_rom_addr), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_draw(0, 0, 0, 0);
    run_draw(2, 3, 2, 0);
    run_draw(3, 12, 6, 0);
    run_draw(0, 0, 0, 1);

    // start held high: two back-to-back draws 403 cycles apart
    sprite_sel = 2'd0; grid_x = 4'd0; grid_y = 4'd0; start = 1'b1;
    ndone = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= 806; c++) begin
      if (c == 806) start = 1'b0;
      if (d_done === 1'b1) ndone++;
      chk_inst("b2b", 1, 1'b0, (c <= 402) ? c : c - 403, 0, 0, 0, 1'b0,
               d_plot, d_x, d_y, d_colour, d_busy, d_done, d_rom_addr);
      @(posedge clk); #1;
    end
    chk("b2b done pulses", ndone, 2);
    repeat (500) @(posedge clk);
    #1;

    run_draw(1, 5, 4, 2);
    run_draw(1, 5, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
